baccarat_statemachine: RTL

//  Sequencing controller for the baccarat datapath, on the other side of its load interface.

---
 rtl/baccarat_statemachine.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/baccarat_statemachine.sv
// rtl/baccarat_statemachine.sv - baccarat dealing sequencer with third-card rules and win lights
//
// Purpose:
//   Converts deal-button presses into one-cycle load strobes for the baccarat
//   datapath (P1, D1, P2, D2, optional P3/D3), applies the third-card rules
//   using the datapath scores, and latches the win lights at game end.
//
// Ports:
//   clk               in   1  rising-edge system clock
//   resetb            in   1  synchronous active-low reset
//   key               in   1  deal button, active-low, asynchronous to clk
//   pcard3            in   4  player third card rank (0 = none, 1..13 = A..K)
//   pscore            in   4  player score 0..9
//   dscore            in   4  dealer score 0..9
//   load_pcard1..3    out  1  one-cycle player card load strobes
//   load_dcard1..3    out  1  one-cycle dealer card load strobes
//   player_win_light  out  1  player won or tied (valid in DONE)
//   dealer_win_light  out  1  dealer won or tied (valid in DONE)

module baccarat_statemachine #(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       key,
  input  logic [3:0] pcard3,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [3:0] {
    DEAL_P1,
    DEAL_D1,
    DEAL_P2,
    DEAL_D2,
    SETTLE,
    DECIDE1,
    DEAL_P3,
    DECIDE2,
    DEAL_D3,
    DONE
  } state_t;

  state_t state, state_n;
  state_t target, target_n;

  logic [CW-1:0]          cnt, cnt_n;
  logic [SYNC_STAGES-1:0] sync;
  logic                   key_sync;
  logic                   key_prev;
  logic                   press;

  logic ld_p1_n, ld_p2_n, ld_p3_n, ld_d1_n, ld_d2_n, ld_d3_n;
  logic [3:0] pc3_value;
  logic       dealer_draw;

  assign key_sync = sync[SYNC_STAGES-1];
  // Falling edge of the synchronised button; holding the key low yields one press.
  assign press    = key_prev & ~key_sync;

  // Tens and face cards count as zero.
  assign pc3_value = (pcard3 >= 4'd10) ? 4'd0 : pcard3;

  // Banker third-card table, indexed by banker score and player's third card value.
  always_comb begin
    dealer_draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: dealer_draw = 1'b1;
      4'd3:             dealer_draw = (pc3_value != 4'd8);
      4'd4:             dealer_draw = (pc3_value >= 4'd2) && (pc3_value <= 4'd7);
      4'd5:             dealer_draw = (pc3_value >= 4'd4) && (pc3_value <= 4'd7);
      4'd6:             dealer_draw = (pc3_value >= 4'd6) && (pc3_value <= 4'd7);
      default:          dealer_draw = 1'b0;
    endcase
  end

  always_comb begin
    state_n  = state;
    target_n = target;
    cnt_n    = cnt;
    ld_p1_n  = 1'b0;
    ld_p2_n  = 1'b0;
    ld_p3_n  = 1'b0;
    ld_d1_n  = 1'b0;
    ld_d2_n  = 1'b0;
    ld_d3_n  = 1'b0;
    case (state)
      DEAL_P1: if (press) begin
        ld_p1_n = 1'b1;
        state_n = DEAL_D1;
      end
      DEAL_D1: if (press) begin
        ld_d1_n = 1'b1;
        state_n = DEAL_P2;
      end
      DEAL_P2: if (press) begin
        ld_p2_n = 1'b1;
        state_n = DEAL_D2;
      end
      DEAL_D2: if (press) begin
        ld_d2_n  = 1'b1;
        state_n  = SETTLE;
        target_n = DECIDE1;
        cnt_n    = '0;
      end
      // The strobe cycle is spent here with cnt=0, followed by SETTLE_CYCLES
      // further cycles, so the datapath scores are stable before use.
      SETTLE: begin
        if (cnt == CW'(SETTLE_CYCLES)) begin
          state_n = target;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DECIDE1: begin
        if ((pscore >= 4'd8) || (dscore >= 4'd8)) begin
          state_n = DONE;
        end else if (pscore <= 4'd5) begin
          state_n = DEAL_P3;
        end else if (dscore <= 4'd5) begin
          state_n = DEAL_D3;
        end else begin
          state_n = DONE;
        end
      end
      DEAL_P3: if (press) begin
        ld_p3_n  = 1'b1;
        state_n  = SETTLE;
        target_n = DECIDE2;
        cnt_n    = '0;
      end
      DECIDE2: state_n = dealer_draw ? DEAL_D3 : DONE;
      DEAL_D3: if (press) begin
        ld_d3_n  = 1'b1;
        state_n  = SETTLE;
        target_n = DONE;
        cnt_n    = '0;
      end
      DONE:    state_n = DONE;
      default: state_n = DEAL_P1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state            <= DEAL_P1;
      target           <= DEAL_P1;
      cnt              <= '0;
      sync             <= '1;
      key_prev         <= 1'b1;
      load_pcard1      <= 1'b0;
      load_pcard2      <= 1'b0;
      load_pcard3      <= 1'b0;
      load_dcard1      <= 1'b0;
      load_dcard2      <= 1'b0;
      load_dcard3      <= 1'b0;
      player_win_light <= 1'b0;
      dealer_win_light <= 1'b0;
    end else begin
      state       <= state_n;
      target      <= target_n;
      cnt         <= cnt_n;
      sync        <= {sync[SYNC_STAGES-2:0], key};
      key_prev    <= key_sync;
      load_pcard1 <= ld_p1_n;
      load_pcard2 <= ld_p2_n;
      load_pcard3 <= ld_p3_n;
      load_dcard1 <= ld_d1_n;
      load_dcard2 <= ld_d2_n;
      load_dcard3 <= ld_d3_n;
      // Lights capture the scores only on the edge that enters DONE.
      if ((state_n == DONE) && (state != DONE)) begin
        player_win_light <= (pscore > dscore) || (pscore == dscore);
        dealer_win_light <= (dscore > pscore) || (pscore == dscore);
      end
    end
  end

endmodule
